// File: rtl/axi4_lite_write_slave_pkg.sv
// Shared AXI4-Lite response codes and the write-slave state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_write_slave_if.sv
// AXI4-Lite write channels plus the single-beat local memory write port.
interface axi4_lite_write_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, mem_ready,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, mem_ready,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write responder: buffers one AW/W pair, range-checks it, issues
// one backend write and returns a B response.
module axi4_lite_write_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    rst,
  axi4_lite_write_slave_if.slave  axi
);

  wr_state_e             state_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            strb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            mem_wstrb_q;

  logic [ADDR_WIDTH:0]   diff_d;
  logic [ADDR_WIDTH-1:0] offset_d;
  logic                  addr_err_d, wr_en_d;

  // Window check via the borrow of addr-BASE and offset>=SIZE: equivalent to
  // the two-sided compare and naturally caps the upper bound at 2^ADDR_WIDTH.
  always_comb begin
    diff_d     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    offset_d   = diff_d[ADDR_WIDTH-1:0];
    addr_err_d = diff_d[ADDR_WIDTH] || (offset_d >= MEM_SIZE) || (addr_q[1:0] != 2'b00);
    wr_en_d    = !addr_err_d && (strb_q != 4'b0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aw_held_q && w_held_q) begin
            state_q  <= ST_WRITE;
            mem_we_q <= wr_en_d;
            if (wr_en_d) begin
              mem_addr_q  <= offset_d;
              mem_wdata_q <= data_q;
              mem_wstrb_q <= strb_q;
            end
          end else begin
            if (!aw_held_q) begin
              if (axi.S_AXI_AWVALID && awready_q) begin
                addr_q    <= axi.S_AXI_AWADDR;
                aw_held_q <= 1'b1;
                awready_q <= 1'b0;
              end else begin
                awready_q <= 1'b1;
              end
            end
            if (!w_held_q) begin
              if (axi.S_AXI_WVALID && wready_q) begin
                data_q   <= axi.S_AXI_WDATA;
                strb_q   <= axi.S_AXI_WSTRB;
                w_held_q <= 1'b1;
                wready_q <= 1'b0;
              end else begin
                wready_q <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (!mem_we_q || axi.mem_ready) begin
            state_q     <= ST_RESP;
            bvalid_q    <= 1'b1;
            bresp_q     <= addr_err_d ? RESP_SLVERR : RESP_OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        ST_RESP: begin
          if (axi.S_AXI_BREADY) begin
            state_q   <= ST_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi.S_AXI_AWREADY = awready_q;
  assign axi.S_AXI_WREADY  = wready_q;
  assign axi.S_AXI_BVALID  = bvalid_q;
  assign axi.S_AXI_BRESP   = bresp_q;
  assign axi.mem_we        = mem_we_q;
  assign axi.mem_addr      = mem_addr_q;
  assign axi.mem_wdata     = mem_wdata_q;
  assign axi.mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Scoreboard bench for axi4_lite_write_slave: expected writes/responses are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_axi4_lite_write_slave;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  axi4_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_write_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (32'h0000_0000),
    .MEM_SIZE  (32'h0000_1000)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .axi(bus)
  );

  always #5 clk = ~clk;

  int chk  = 0;
  int pass = 0;

  wr_t        exp_wr_q[$], obs_wr_q[$];
  logic [1:0] exp_b_q[$],  obs_b_q[$];

  int we_cycles, t_we, t_b, b_cycles;
  bit b_done, unstable, leak, aw_in_b, b_unstable;

  // Drive AW until accepted; returns at the negedge after the handshake edge.
  task automatic hs_aw(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.S_AXI_AWREADY) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_AWADDR  = '0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s, output bit ok);
    ok = 1'b0;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
    bus.S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.S_AXI_WREADY) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WDATA  = '0;
    bus.S_AXI_WSTRB  = '0;
  endtask

  task automatic hs_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output bit ok);
    ok = 1'b0;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
  endtask

  // Acts as backend and B master: records accepted writes and the response,
  // timing (index 0 = negedge right after the last handshake) and stability.
  task automatic observe(input int stall, input int bhold, input int budget);
    wr_t        snap;
    logic [1:0] bsnap;
    we_cycles = 0; b_cycles = 0; t_we = -1; t_b = -1;
    b_done = 0; unstable = 0; leak = 0; aw_in_b = 0; b_unstable = 0;
    snap = '0; bsnap = 2'b00;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.mem_we) begin
        if (we_cycles == 0) begin
          t_we = i;
          snap = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
        end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== snap) begin
          unstable = 1;
        end
        we_cycles++;
        bus.mem_ready = (we_cycles > stall);
        if (bus.mem_ready) obs_wr_q.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
      end else begin
        bus.mem_ready = (stall == 0);
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} != '0) leak = 1;
      end
      if (bus.S_AXI_BVALID) begin
        if (t_b < 0) begin t_b = i; bsnap = bus.S_AXI_BRESP; end
        else if (bus.S_AXI_BRESP !== bsnap) b_unstable = 1;
        b_cycles++;
        if (bus.S_AXI_AWREADY) aw_in_b = 1;
        bus.S_AXI_BREADY = (b_cycles > bhold);
        if (bus.S_AXI_BREADY) begin
          obs_b_q.push_back(bus.S_AXI_BRESP);
          @(posedge clk);
          b_done = 1;
          break;
        end
      end else begin
        bus.S_AXI_BREADY = (bhold == 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.mem_we, bus.S_AXI_BRESP,
         bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== '0)
      $display("FAIL reset_state: aw/w/b/we=%b%b%b%b bresp=%b mem=%h/%h/%h want all 0",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.mem_we,
               bus.S_AXI_BRESP, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else pass++;
    repeat (2) @(negedge clk);
    chk++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b00)
      $display("FAIL reset_hold_readies: got %b%b want 00", bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    else pass++;
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b110)
      $display("FAIL reset_release_readies: aw/w/b got %b%b%b want 110",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID);
    else pass++;
  endtask

  task automatic test_same_cycle();
    wr_t o, e; logic [1:0] ob, eb; bit ok;
    exp_wr_q.push_back({32'h10, 32'hDEADBEEF, 4'hF});
    exp_b_q.push_back(2'b00);
    hs_both(32'h10, 32'hDEADBEEF, 4'hF, ok);
    chk++;
    if (!ok || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b00)
      $display("FAIL same_handshake: ok=%0d readies=%b%b want 1 and 00", ok,
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    else pass++;
    observe(0, 0, 20);
    chk++;
    if (!b_done || we_cycles != 1 || t_we != 1 || t_b != 2)
      $display("FAIL same_latency: done=%0d we_cycles=%0d t_we=%0d t_b=%0d want 1/1/1/2",
               b_done, we_cycles, t_we, t_b);
    else pass++;
    chk++;
    if (obs_wr_q.size() != exp_wr_q.size() || obs_b_q.size() != exp_b_q.size())
      $display("FAIL same_sb_count: wr %0d/%0d b %0d/%0d", obs_wr_q.size(), exp_wr_q.size(),
               obs_b_q.size(), exp_b_q.size());
    else begin
      pass++;
      while (obs_wr_q.size() > 0) begin
        o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
        chk++; if (o !== e) $display("FAIL same_write: got %h want %h", o, e); else pass++;
      end
      while (obs_b_q.size() > 0) begin
        ob = obs_b_q.pop_front(); eb = exp_b_q.pop_front();
        chk++; if (ob !== eb) $display("FAIL same_bresp: got %b want %b", ob, eb); else pass++;
      end
    end
    exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
    chk++;
    if (leak || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b110)
      $display("FAIL same_after: leak=%0d aw/w/b=%b%b%b want 0 and 110", leak,
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID);
    else pass++;
  endtask

  task automatic test_w_first();
    wr_t o, e; logic [1:0] ob, eb; bit ok, bad;
    exp_wr_q.push_back({32'h20, 32'hCAFEF00D, 4'b0110});
    exp_b_q.push_back(2'b00);
    hs_w(32'hCAFEF00D, 4'b0110, ok);
    bad = !ok;
    for (int i = 0; i < 2; i++) begin
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.mem_we, bus.S_AXI_BVALID} !== 4'b1000) bad = 1;
      @(negedge clk);
    end
    chk++;
    if (bad || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.mem_we} !== 3'b100)
      $display("FAIL wfirst_wait: aw/w/we/b=%b%b%b%b want 1000 while AW absent",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.mem_we, bus.S_AXI_BVALID);
    else pass++;
    hs_aw(32'h20, ok);
    observe(0, 0, 20);
    chk++;
    if (!ok || !b_done || we_cycles != 1 || t_we != 1 || t_b != 2)
      $display("FAIL wfirst_latency: ok=%0d done=%0d we_cycles=%0d t_we=%0d t_b=%0d want 1/1/1/1/2",
               ok, b_done, we_cycles, t_we, t_b);
    else pass++;
    chk++;
    if (obs_wr_q.size() != exp_wr_q.size() || obs_b_q.size() != exp_b_q.size())
      $display("FAIL wfirst_sb_count: wr %0d/%0d b %0d/%0d", obs_wr_q.size(), exp_wr_q.size(),
               obs_b_q.size(), exp_b_q.size());
    else begin
      pass++;
      while (obs_wr_q.size() > 0) begin
        o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
        chk++; if (o !== e) $display("FAIL wfirst_write: got %h want %h", o, e); else pass++;
      end
      while (obs_b_q.size() > 0) begin
        ob = obs_b_q.pop_front(); eb = exp_b_q.pop_front();
        chk++; if (ob !== eb) $display("FAIL wfirst_bresp: got %b want %b", ob, eb); else pass++;
      end
    end
    exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
  endtask

  // Window/alignment/strobe boundaries; a suppressed write keeps the same B latency.
  task automatic test_decode();
    logic [31:0] addrs[7] = '{32'h1000, 32'h22, 32'hFFFF_FFFC, 32'h1, 32'hFFC, 32'hFFC, 32'h0};
    logic [3:0]  strbs[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 4'h0, 4'hF};
    bit          errs[7]  = '{1, 1, 1, 1, 0, 0, 0};
    wr_t o, e; logic [1:0] ob, eb; bit ok; bit exp_we; logic [31:0] d;
    for (int k = 0; k < 7; k++) begin
      d = 32'h0BAD_0000 + k;
      exp_we = !errs[k] && (strbs[k] != 4'h0);
      if (exp_we) exp_wr_q.push_back({addrs[k], d, strbs[k]});
      exp_b_q.push_back(errs[k] ? 2'b10 : 2'b00);
      hs_both(addrs[k], d, strbs[k], ok);
      observe(0, 0, 20);
      chk++;
      if (!ok || !b_done || t_b != 2 || we_cycles != int'(exp_we))
        $display("FAIL decode_timing[%h]: ok=%0d done=%0d t_b=%0d we_cycles=%0d want 1/1/2/%0d",
                 addrs[k], ok, b_done, t_b, we_cycles, exp_we);
      else pass++;
      chk++;
      if (obs_wr_q.size() != exp_wr_q.size() || obs_b_q.size() != exp_b_q.size())
        $display("FAIL decode_sb_count[%h]: wr %0d/%0d b %0d/%0d", addrs[k], obs_wr_q.size(),
                 exp_wr_q.size(), obs_b_q.size(), exp_b_q.size());
      else begin
        pass++;
        while (obs_wr_q.size() > 0) begin
          o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
          chk++; if (o !== e) $display("FAIL decode_write[%h]: got %h want %h", addrs[k], o, e); else pass++;
        end
        while (obs_b_q.size() > 0) begin
          ob = obs_b_q.pop_front(); eb = exp_b_q.pop_front();
          chk++; if (ob !== eb) $display("FAIL decode_bresp[%h]: got %b want %b", addrs[k], ob, eb); else pass++;
        end
      end
      exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
    end
  endtask

  task automatic test_mem_stall();
    wr_t o, e; bit ok;
    exp_wr_q.push_back({32'h40, 32'hA5A5_5A5A, 4'b1001});
    hs_both(32'h40, 32'hA5A5_5A5A, 4'b1001, ok);
    observe(5, 0, 30);
    chk++;
    if (!ok || !b_done || we_cycles != 6 || unstable || t_we != 1 || t_b != 7)
      $display("FAIL stall_hold: ok=%0d done=%0d we_cycles=%0d unstable=%0d t_we=%0d t_b=%0d want 1/1/6/0/1/7",
               ok, b_done, we_cycles, unstable, t_we, t_b);
    else pass++;
    chk++;
    if (obs_wr_q.size() != 1 || obs_b_q.size() != 1)
      $display("FAIL stall_sb_count: wr %0d b %0d want 1 1", obs_wr_q.size(), obs_b_q.size());
    else begin
      pass++;
      o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
      chk++; if (o !== e) $display("FAIL stall_write: got %h want %h", o, e); else pass++;
      chk++;
      if (obs_b_q[0] !== 2'b00) $display("FAIL stall_bresp: got %b want 00", obs_b_q[0]); else pass++;
    end
    exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
  endtask

  task automatic test_bready_hold();
    wr_t o, e; logic [1:0] ob, eb; bit ok, ok2;
    exp_wr_q.push_back({32'h30, 32'h1111_2222, 4'hF});
    exp_b_q.push_back(2'b00);
    hs_both(32'h30, 32'h1111_2222, 4'hF, ok);
    bus.S_AXI_AWADDR  = 32'h34;
    bus.S_AXI_AWVALID = 1'b1;
    observe(0, 4, 30);
    chk++;
    if (!ok || !b_done || b_cycles != 5 || b_unstable || aw_in_b)
      $display("FAIL bhold_resp: ok=%0d done=%0d b_cycles=%0d b_unstable=%0d aw_in_b=%0d want 1/1/5/0/0",
               ok, b_done, b_cycles, b_unstable, aw_in_b);
    else pass++;
    chk++;
    if (bus.S_AXI_AWREADY !== 1'b1)
      $display("FAIL bhold_aw_after_b: awready=%b want 1", bus.S_AXI_AWREADY);
    else pass++;
    hs_aw(32'h34, ok2);
    chk++;
    if (!ok2 || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b01)
      $display("FAIL bhold_second_aw: ok=%0d readies=%b%b want 1 and 01", ok2,
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    else pass++;
    exp_wr_q.push_back({32'h34, 32'h3333_4444, 4'h5});
    exp_b_q.push_back(2'b00);
    hs_w(32'h3333_4444, 4'h5, ok2);
    observe(0, 0, 20);
    chk++;
    if (!ok2 || !b_done || t_we != 1 || t_b != 2)
      $display("FAIL bhold_second_txn: ok=%0d done=%0d t_we=%0d t_b=%0d want 1/1/1/2",
               ok2, b_done, t_we, t_b);
    else pass++;
    chk++;
    if (obs_wr_q.size() != exp_wr_q.size() || obs_b_q.size() != exp_b_q.size())
      $display("FAIL bhold_sb_count: wr %0d/%0d b %0d/%0d", obs_wr_q.size(), exp_wr_q.size(),
               obs_b_q.size(), exp_b_q.size());
    else begin
      pass++;
      while (obs_wr_q.size() > 0) begin
        o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
        chk++; if (o !== e) $display("FAIL bhold_write: got %h want %h", o, e); else pass++;
      end
      while (obs_b_q.size() > 0) begin
        ob = obs_b_q.pop_front(); eb = exp_b_q.pop_front();
        chk++; if (ob !== eb) $display("FAIL bhold_bresp: got %b want %b", ob, eb); else pass++;
      end
    end
    exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
  endtask

  task automatic test_reset_in_resp();
    wr_t o, e; logic [1:0] ob; bit ok; int n;
    bus.S_AXI_BREADY = 1'b0;
    bus.mem_ready    = 1'b1;
    exp_wr_q.push_back({32'h8, 32'h1234_5678, 4'h3});
    hs_both(32'h8, 32'h1234_5678, 4'h3, ok);
    n = 0;
    while (!bus.S_AXI_BVALID && n < 10) begin
      if (bus.mem_we) obs_wr_q.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
      @(negedge clk);
      n++;
    end
    chk++;
    if (!ok || bus.S_AXI_BVALID !== 1'b1 || obs_wr_q.size() != 1)
      $display("FAIL rstresp_reach: ok=%0d bvalid=%b writes=%0d want 1/1/1", ok,
               bus.S_AXI_BVALID, obs_wr_q.size());
    else begin
      pass++;
      o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
      chk++; if (o !== e) $display("FAIL rstresp_write: got %h want %h", o, e); else pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
    rst_n = 1'b0;
    #1;
    chk++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.mem_we} !== 4'b0000)
      $display("FAIL rstresp_async: b/aw/w/we=%b%b%b%b want 0000", bus.S_AXI_BVALID,
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.mem_we);
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b110)
      $display("FAIL rstresp_release: aw/w/b=%b%b%b want 110", bus.S_AXI_AWREADY,
               bus.S_AXI_WREADY, bus.S_AXI_BVALID);
    else pass++;
    exp_wr_q.push_back({32'h4, 32'h0F0F_F0F0, 4'hF});
    exp_b_q.push_back(2'b00);
    hs_both(32'h4, 32'h0F0F_F0F0, 4'hF, ok);
    observe(0, 0, 20);
    chk++;
    if (!ok || !b_done || obs_wr_q.size() != 1 || obs_b_q.size() != 1 || t_b != 2)
      $display("FAIL rstresp_fresh: ok=%0d done=%0d writes=%0d resps=%0d t_b=%0d want 1/1/1/1/2",
               ok, b_done, obs_wr_q.size(), obs_b_q.size(), t_b);
    else begin
      pass++;
      o = obs_wr_q.pop_front(); e = exp_wr_q.pop_front();
      chk++; if (o !== e) $display("FAIL rstresp_fresh_write: got %h want %h", o, e); else pass++;
      ob = obs_b_q.pop_front();
      chk++; if (ob !== exp_b_q.pop_front()) $display("FAIL rstresp_fresh_bresp: got %b want 00", ob); else pass++;
    end
    exp_wr_q.delete(); exp_b_q.delete(); obs_wr_q.delete(); obs_b_q.delete();
  endtask

  initial begin
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.mem_ready     = 1'b0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_decode();
    test_mem_stall();
    test_bready_hold();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass, chk);
    $fatal(1);
  end

endmodule
